// File: rtl/rename_pkg.sv
// Shared types for the rename recovery slice: register indices, history entry layout
// and recovery controller states.
package rename_pkg;

    localparam int ARCH_W     = 5;
    localparam int PHYS_W     = 6;
    localparam int HIST_DEPTH = 32;

    typedef logic [ARCH_W-1:0] ArchReg_t;
    typedef logic [PHYS_W-1:0] PhysReg_t;

    typedef struct packed {
        logic     has_dest;
        ArchReg_t arch;
        PhysReg_t old_phys;
        PhysReg_t new_phys;
    } RenameHist_t;

    localparam int HIST_W = $bits(RenameHist_t);

    typedef enum logic {
        NORMAL = 1'b0,
        WALK   = 1'b1
    } RecovState_t;

endpackage

// File: rtl/rename_hist_buf.sv
// Rename history ring storage: one write port, async reads at the oldest entry
// and at the youngest entry (tail-1). Storage is deliberately not reset.
module rename_hist_buf
    import rename_pkg::*;
#(
    parameter int DEPTH    = HIST_DEPTH,
    parameter int IDX_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [HIST_W-1:0]   wr_data,
    input  logic [IDX_BITS-1:0] head_idx,
    output logic [HIST_W-1:0]   head_data,
    input  logic [IDX_BITS-1:0] tail_idx,
    output logic [HIST_W-1:0]   tail_data
);

    logic [HIST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign head_data = mem[head_idx];
    assign tail_data = mem[tail_idx];

endmodule

// File: rtl/rename_recovery_ctrl.sv
// Rename history controller: records every rename, frees old mappings on commit and
// unwinds squashed renames youngest-first after a mispredict.
module rename_recovery_ctrl
    import rename_pkg::*;
#(
    parameter int ARCH_BITS = ARCH_W,
    parameter int PHYS_BITS = PHYS_W,
    parameter int DEPTH     = HIST_DEPTH,
    localparam int IDX_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ren_valid,
    input  logic                 ren_has_dest,
    input  logic [ARCH_BITS-1:0] ren_arch,
    input  logic [PHYS_BITS-1:0] ren_old_phys,
    input  logic [PHYS_BITS-1:0] ren_new_phys,
    output logic                 ren_ready,
    output logic [IDX_BITS-1:0]  ren_tag,
    input  logic                 commit_valid,
    output logic                 commit_ready,
    input  logic                 flush_valid,
    input  logic [IDX_BITS-1:0]  flush_tag,
    output logic                 rmt_wr_en,
    output logic [ARCH_BITS-1:0] rmt_wr_arch,
    output logic [PHYS_BITS-1:0] rmt_wr_phys,
    output logic                 fl_push,
    output logic [PHYS_BITS-1:0] fl_push_phys,
    output logic                 busy_clr,
    output logic [PHYS_BITS-1:0] busy_clr_phys,
    output logic                 recovering,
    output logic [IDX_BITS:0]    count
);

    localparam logic [IDX_BITS:0] PTR_ONE = (IDX_BITS+1)'(1);

    RecovState_t        state;
    logic [IDX_BITS:0]  head;
    logic [IDX_BITS:0]  tail;
    logic [IDX_BITS:0]  stop;

    logic               full;
    logic               empty;
    logic               ren_fire;
    logic               commit_fire;
    logic [IDX_BITS:0]  tail_m1;
    logic [IDX_BITS-1:0] flush_off;
    logic [IDX_BITS:0]  flush_ptr;
    logic [IDX_BITS:0]  flush_stop;
    logic [IDX_BITS:0]  walk_span;
    logic               flush_hit_normal;
    logic               flush_hit_walk;

    RenameHist_t        wr_ent;
    RenameHist_t        head_ent;
    RenameHist_t        tail_ent;
    logic [HIST_W-1:0]  head_raw;
    logic [HIST_W-1:0]  tail_raw;

    assign empty        = (head == tail);
    assign full         = (head[IDX_BITS] != tail[IDX_BITS]) &&
                          (head[IDX_BITS-1:0] == tail[IDX_BITS-1:0]);
    assign count        = tail - head;
    assign ren_ready    = (state == NORMAL) && !full && !flush_valid;
    assign commit_ready = (state == NORMAL) && !empty;
    assign ren_tag      = tail[IDX_BITS-1:0];
    assign ren_fire     = ren_valid && ren_ready;
    assign commit_fire  = commit_valid && commit_ready;
    assign recovering   = (state == WALK);
    assign tail_m1      = tail - PTR_ONE;

    // Flush tag is located by its distance from head so the range test survives wrap.
    assign flush_off        = flush_tag - head[IDX_BITS-1:0];
    assign flush_ptr        = head + {1'b0, flush_off};
    assign flush_stop       = flush_ptr + PTR_ONE;
    assign walk_span        = stop - head;
    assign flush_hit_normal = flush_valid && ({1'b0, flush_off} < count);
    assign flush_hit_walk   = flush_valid && (walk_span != '0) &&
                              ({1'b0, flush_off} < (walk_span - PTR_ONE));

    assign wr_ent   = '{has_dest: ren_has_dest, arch: ren_arch,
                        old_phys: ren_old_phys, new_phys: ren_new_phys};
    assign head_ent = RenameHist_t'(head_raw);
    assign tail_ent = RenameHist_t'(tail_raw);

    rename_hist_buf #(
        .DEPTH    (DEPTH),
        .IDX_BITS (IDX_BITS)
    ) u_hist (
        .clk       (clk),
        .wr_en     (ren_fire),
        .wr_idx    (tail[IDX_BITS-1:0]),
        .wr_data   (wr_ent),
        .head_idx  (head[IDX_BITS-1:0]),
        .head_data (head_raw),
        .tail_idx  (tail_m1[IDX_BITS-1:0]),
        .tail_data (tail_raw)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= NORMAL;
            head          <= '0;
            tail          <= '0;
            stop          <= '0;
            rmt_wr_en     <= 1'b0;
            rmt_wr_arch   <= '0;
            rmt_wr_phys   <= '0;
            fl_push       <= 1'b0;
            fl_push_phys  <= '0;
            busy_clr      <= 1'b0;
            busy_clr_phys <= '0;
        end else begin
            rmt_wr_en     <= 1'b0;
            rmt_wr_arch   <= '0;
            rmt_wr_phys   <= '0;
            fl_push       <= 1'b0;
            fl_push_phys  <= '0;
            busy_clr      <= 1'b0;
            busy_clr_phys <= '0;
            case (state)
                NORMAL: begin
                    if (ren_fire) begin
                        tail <= tail + PTR_ONE;
                    end
                    if (commit_fire) begin
                        head <= head + PTR_ONE;
                        if (head_ent.has_dest) begin
                            fl_push      <= 1'b1;
                            fl_push_phys <= head_ent.old_phys;
                        end
                    end
                    if (flush_hit_normal) begin
                        stop <= flush_stop;
                        if (tail != flush_stop) begin
                            state <= WALK;
                        end
                    end
                end
                WALK: begin
                    tail <= tail_m1;
                    if (tail_ent.has_dest) begin
                        rmt_wr_en     <= 1'b1;
                        rmt_wr_arch   <= tail_ent.arch;
                        rmt_wr_phys   <= tail_ent.old_phys;
                        fl_push       <= 1'b1;
                        fl_push_phys  <= tail_ent.new_phys;
                        busy_clr      <= 1'b1;
                        busy_clr_phys <= tail_ent.new_phys;
                    end
                    // A deeper flush always lands below tail_m1, so the walk keeps going.
                    if (flush_hit_walk) begin
                        stop <= flush_stop;
                    end else if (tail_m1 == stop) begin
                        state <= NORMAL;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_rename_recovery_ctrl.sv
// Directed bench for rename_recovery_ctrl: commit frees, full ring, flush walks,
// nested flush, wrap-around and reset during recovery.
module tb_rename_recovery_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ren_valid;
    logic       ren_has_dest;
    logic [4:0] ren_arch;
    logic [5:0] ren_old_phys;
    logic [5:0] ren_new_phys;
    logic       ren_ready;
    logic [4:0] ren_tag;
    logic       commit_valid;
    logic       commit_ready;
    logic       flush_valid;
    logic [4:0] flush_tag;
    logic       rmt_wr_en;
    logic [4:0] rmt_wr_arch;
    logic [5:0] rmt_wr_phys;
    logic       fl_push;
    logic [5:0] fl_push_phys;
    logic       busy_clr;
    logic [5:0] busy_clr_phys;
    logic       recovering;
    logic [5:0] count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rename_recovery_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ren_valid     (ren_valid),
        .ren_has_dest  (ren_has_dest),
        .ren_arch      (ren_arch),
        .ren_old_phys  (ren_old_phys),
        .ren_new_phys  (ren_new_phys),
        .ren_ready     (ren_ready),
        .ren_tag       (ren_tag),
        .commit_valid  (commit_valid),
        .commit_ready  (commit_ready),
        .flush_valid   (flush_valid),
        .flush_tag     (flush_tag),
        .rmt_wr_en     (rmt_wr_en),
        .rmt_wr_arch   (rmt_wr_arch),
        .rmt_wr_phys   (rmt_wr_phys),
        .fl_push       (fl_push),
        .fl_push_phys  (fl_push_phys),
        .busy_clr      (busy_clr),
        .busy_clr_phys (busy_clr_phys),
        .recovering    (recovering),
        .count         (count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic hd, input logic [4:0] arch,
                                 input logic [5:0] oldp, input logic [5:0] newp,
                                 input logic cv, input logic fv, input logic [4:0] ftag);
        ren_valid    = rv;
        ren_has_dest = hd;
        ren_arch     = arch;
        ren_old_phys = oldp;
        ren_new_phys = newp;
        commit_valid = cv;
        flush_valid  = fv;
        flush_tag    = ftag;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Registered side effects of one walk step for an entry that writes a register.
    task automatic checkRestore(input string tag, input logic [4:0] arch,
                                input logic [5:0] oldp, input logic [5:0] newp);
        checkOutput({tag, "_rmt_en"}, rmt_wr_en, 1'b1);
        checkOutput({tag, "_rmt_arch"}, rmt_wr_arch, arch);
        checkOutput({tag, "_rmt_phys"}, rmt_wr_phys, oldp);
        checkOutput({tag, "_fl_phys"}, fl_push_phys, newp);
        checkOutput({tag, "_busy_phys"}, busy_clr_phys, newp);
        checkOutput({tag, "_busy_en"}, busy_clr, 1'b1);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        checkOutput("rst_count", count, 0);
        checkOutput("rst_recovering", recovering, 0);
        checkOutput("rst_fl_push", fl_push, 0);
        checkOutput("rst_rmt_wr_en", rmt_wr_en, 0);
        checkOutput("rst_busy_clr", busy_clr, 0);
        checkOutput("rst_ren_ready", ren_ready, 1);
        checkOutput("rst_commit_ready", commit_ready, 0);
        rst_n = 1'b1;

        // Three renames, then two commits free old phys 1 and 2.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(i + 1), 6'(i + 1), 6'(40 + i), 1'b0, 1'b0, 5'd0);
            checkOutput("t1_tag", ren_tag, i);
            checkOutput("t1_ready", ren_ready, 1);
            tick();
        end
        checkOutput("t1_count3", count, 3);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0, 5'd0);
        tick();
        checkOutput("t1_push1", fl_push, 1);
        checkOutput("t1_push1_phys", fl_push_phys, 1);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0, 5'd0);
        tick();
        checkOutput("t1_push2", fl_push, 1);
        checkOutput("t1_push2_phys", fl_push_phys, 2);
        idle();
        tick();
        checkOutput("t1_push_pulse", fl_push, 0);
        checkOutput("t1_count1", count, 1);

        // Flush at the youngest entry and outside the live range: no walk.
        applyStimulus(1'b1, 1'b1, 5'd9, 6'd9, 6'd9, 1'b0, 1'b1, 5'd2);
        checkOutput("t4_ren_blocked", ren_ready, 0);
        tick();
        checkOutput("t4_young_recov", recovering, 0);
        checkOutput("t4_young_count", count, 1);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1, 5'd7);
        tick();
        checkOutput("t4_out_recov", recovering, 0);
        checkOutput("t4_out_rmt", rmt_wr_en, 0);
        checkOutput("t4_out_count", count, 1);
        idle();

        // Fill the ring; a simultaneous commit does not unblock rename.
        doReset();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(i), 6'(i + 10), 6'(i + 20), 1'b0, 1'b0, 5'd0);
            tick();
        end
        checkOutput("t2_count32", count, 32);
        checkOutput("t2_full_ready", ren_ready, 0);
        checkOutput("t2_commit_ready", commit_ready, 1);
        applyStimulus(1'b1, 1'b1, 5'd7, 6'd7, 6'd7, 1'b1, 1'b0, 5'd0);
        checkOutput("t2_both_ready", ren_ready, 0);
        tick();
        checkOutput("t2_count31", count, 31);
        checkOutput("t2_push_phys", fl_push_phys, 10);

        // Tags 0..5 live, flush at 2 undoes 5,4,3.
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(10 + i), 6'(20 + i), 6'(50 + i), 1'b0, 1'b0, 5'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1, 5'd2);
        tick();
        idle();
        checkOutput("t3_recov0", recovering, 1);
        checkOutput("t3_flush_edge_rmt", rmt_wr_en, 0);
        checkOutput("t3_walk_ren", ren_ready, 0);
        checkOutput("t3_walk_commit", commit_ready, 0);
        tick();
        checkRestore("t3_tag5", 5'd15, 6'd25, 6'd55);
        checkOutput("t3_recov1", recovering, 1);
        tick();
        checkRestore("t3_tag4", 5'd14, 6'd24, 6'd54);
        checkOutput("t3_recov2", recovering, 1);
        tick();
        checkRestore("t3_tag3", 5'd13, 6'd23, 6'd53);
        checkOutput("t3_recov_done", recovering, 0);
        tick();
        checkOutput("t3_pulse_end", rmt_wr_en, 0);
        checkOutput("t3_ready", ren_ready, 1);
        checkOutput("t3_tail", ren_tag, 3);

        // Walk toward stop 5 deepened by a second flush at tag 2.
        for (int i = 3; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(10 + i), 6'(20 + i), 6'(50 + i), 1'b0, 1'b0, 5'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1, 5'd4);
        tick();
        checkOutput("t6_recov", recovering, 1);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1, 5'd2);
        tick();
        idle();
        checkRestore("t6_tag5", 5'd15, 6'd25, 6'd55);
        checkOutput("t6_still_recov", recovering, 1);
        tick();
        checkRestore("t6_tag4", 5'd14, 6'd24, 6'd54);
        tick();
        checkRestore("t6_tag3", 5'd13, 6'd23, 6'd53);
        checkOutput("t6_done", recovering, 0);
        checkOutput("t6_count", count, 3);

        // Reset in the middle of a walk.
        for (int i = 3; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(10 + i), 6'(20 + i), 6'(50 + i), 1'b0, 1'b0, 5'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1, 5'd0);
        tick();
        idle();
        tick();
        checkOutput("t6r_walking", rmt_wr_en, 1);
        rst_n = 1'b0;
        tick();
        checkOutput("t6r_rmt", rmt_wr_en, 0);
        checkOutput("t6r_fl", fl_push, 0);
        checkOutput("t6r_busy", busy_clr, 0);
        checkOutput("t6r_recov", recovering, 0);
        checkOutput("t6r_count", count, 0);
        rst_n = 1'b1;

        // Move head to 30 with no-dest fillers, then a walk across the wrap.
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 1'b0, 5'd0, 6'd0, 6'd0, (i > 0), 1'b0, 5'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b1, 1'b0, 5'd0);
        tick();
        checkOutput("t5_nodest_push", fl_push, 0);
        checkOutput("t5_empty", count, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, (k != 3), 5'(k + 1), 6'(30 + k), 6'(56 + k), 1'b0, 1'b0, 5'd0);
            checkOutput("t5_tag", ren_tag, (30 + k) % 32);
            tick();
        end
        checkOutput("t5_count6", count, 6);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 1'b1, 5'd31);
        tick();
        idle();
        checkOutput("t5_recov", recovering, 1);
        tick();
        checkRestore("t5_tag3", 5'd6, 6'd35, 6'd61);
        tick();
        checkRestore("t5_tag2", 5'd5, 6'd34, 6'd60);
        tick();
        checkOutput("t5_tag1_rmt", rmt_wr_en, 0);
        checkOutput("t5_tag1_fl", fl_push, 0);
        checkOutput("t5_tag1_recov", recovering, 1);
        tick();
        checkRestore("t5_tag0", 5'd3, 6'd32, 6'd58);
        checkOutput("t5_done", recovering, 0);
        checkOutput("t5_count2", count, 2);
        checkOutput("t5_tail", ren_tag, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
